// File: rtl/axi_rd_throttle_pkg.sv
// Shared types and helpers for the AXI read-path stall injector.
// Provides the LFSR step, the per-mille token compare and the AR/R control-field layouts.
package axi_rd_throttle_pkg;

  localparam int unsigned LFSR_W     = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam int unsigned PROB_SCALE = 1000;

  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
  } ar_ctrl_t;

  typedef struct packed {
    logic [1:0] resp;
    logic       last;
  } r_ctrl_t;

  localparam int unsigned AR_CTRL_W = $bits(ar_ctrl_t);
  localparam int unsigned R_CTRL_W  = $bits(r_ctrl_t);

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic [LFSR_W-1:0] bit_rev(input logic [LFSR_W-1:0] v);
    logic [LFSR_W-1:0] res;
    for (int unsigned i = 0; i < LFSR_W; i++) res[i] = v[LFSR_W-1-i];
    return res;
  endfunction

  // Scales the LFSR state into [0,1000) and compares against the per-mille probability.
  function automatic logic prob_hit(input logic [LFSR_W-1:0] lfsr, input int unsigned prob);
    logic [31:0] scaled;
    scaled = 32'(lfsr) * 32'(PROB_SCALE);
    if (prob >= PROB_SCALE) return 1'b1;
    if (prob == 0) return 1'b0;
    return {16'd0, scaled[31:16]} < prob;
  endfunction

endpackage

// File: rtl/axi_rd_throttle_skid.sv
// Generic 2-entry valid/ready slice whose READY and VALID are gated by per-cycle tokens.
// Once VALID is presented it is held, with stable payload, until the downstream handshake.
module axi_skid_throttle #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_v_ok,
  input  logic         i_r_ok,
  input  logic         i_s_valid,
  output logic         o_s_ready_c,
  input  logic [W-1:0] i_s_data,
  output logic         o_m_valid_c,
  input  logic         i_m_ready,
  output logic [W-1:0] o_m_data_c,
  output logic [1:0]   o_count
);
  localparam int unsigned DEPTH = 2;

  logic [W-1:0] r_mem [DEPTH];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         r_held;
  logic         w_push;
  logic         w_pop;

  assign o_s_ready_c = (r_count < 2'(DEPTH)) & i_r_ok;
  assign o_m_valid_c = (r_count != 2'd0) & (r_held | i_v_ok);
  assign o_m_data_c  = r_mem[r_rd_ptr];
  assign o_count     = r_count;
  assign w_push      = i_s_valid & o_s_ready_c;
  assign w_pop       = o_m_valid_c & i_m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_held   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_s_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      // A presented beat stays presented until it is taken.
      r_held <= o_m_valid_c & ~i_m_ready;
    end
  end

endmodule

// File: rtl/axi_rd_throttle.sv
// AXI4 read-path stall injector: AR and R pass through throttled 2-entry slices.
// Counts cycles in which a buffered beat was withheld from the downstream side.
module axi_rd_throttle
  import axi_rd_throttle_pkg::*;
#(
  parameter int unsigned ID_W       = 6,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned VALID_PROB = 1000,
  parameter int unsigned READY_PROB = 1000,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   s_arid,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [7:0]        s_arlen,
  input  logic [2:0]        s_arsize,
  input  logic [1:0]        s_arburst,
  input  logic              s_arlock,
  input  logic [3:0]        s_arcache,
  input  logic [2:0]        s_arprot,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [ID_W-1:0]   m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arlock,
  output logic [3:0]        m_arcache,
  output logic [2:0]        m_arprot,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [ID_W-1:0]   m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [ID_W-1:0]   s_rid,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [31:0]       stall_cnt
);
  localparam int unsigned AR_W = ID_W + ADDR_W + AR_CTRL_W;
  localparam int unsigned R_W  = ID_W + DATA_W + R_CTRL_W;
  localparam logic [LFSR_W-1:0] R_SEED = SEED ^ 16'h5A5A;

  logic              r_live;
  logic [LFSR_W-1:0] r_ar_lfsr;
  logic [LFSR_W-1:0] r_r_lfsr;
  logic [31:0]       r_stall_cnt;

  ar_ctrl_t          w_s_ar_ctrl;
  ar_ctrl_t          w_m_ar_ctrl;
  r_ctrl_t           w_m_r_ctrl;
  r_ctrl_t           w_s_r_ctrl;
  logic [AR_W-1:0]   w_ar_in;
  logic [AR_W-1:0]   w_ar_out;
  logic [R_W-1:0]    w_r_in;
  logic [R_W-1:0]    w_r_out;
  logic [1:0]        w_ar_count;
  logic [1:0]        w_r_count;
  logic              w_ar_v_ok;
  logic              w_ar_r_ok;
  logic              w_r_v_ok;
  logic              w_r_r_ok;
  logic              w_stall;

  // READY stays low until the first clock after reset release.
  assign w_ar_v_ok = prob_hit(r_ar_lfsr, VALID_PROB);
  assign w_ar_r_ok = r_live & prob_hit(bit_rev(r_ar_lfsr), READY_PROB);
  assign w_r_v_ok  = prob_hit(r_r_lfsr, VALID_PROB);
  assign w_r_r_ok  = r_live & prob_hit(bit_rev(r_r_lfsr), READY_PROB);

  assign w_s_ar_ctrl = '{len: s_arlen, size: s_arsize, burst: s_arburst,
                         lock: s_arlock, cache: s_arcache, prot: s_arprot};
  assign w_ar_in     = {s_arid, s_araddr, w_s_ar_ctrl};
  assign {m_arid, m_araddr, w_m_ar_ctrl} = w_ar_out;
  assign m_arlen     = w_m_ar_ctrl.len;
  assign m_arsize    = w_m_ar_ctrl.size;
  assign m_arburst   = w_m_ar_ctrl.burst;
  assign m_arlock    = w_m_ar_ctrl.lock;
  assign m_arcache   = w_m_ar_ctrl.cache;
  assign m_arprot    = w_m_ar_ctrl.prot;

  assign w_m_r_ctrl  = '{resp: m_rresp, last: m_rlast};
  assign w_r_in      = {m_rid, m_rdata, w_m_r_ctrl};
  assign {s_rid, s_rdata, w_s_r_ctrl} = w_r_out;
  assign s_rresp     = w_s_r_ctrl.resp;
  assign s_rlast     = w_s_r_ctrl.last;

  axi_skid_throttle #(.W(AR_W)) u_ar (
    .clk         (clk),
    .rst         (rst),
    .i_v_ok      (w_ar_v_ok),
    .i_r_ok      (w_ar_r_ok),
    .i_s_valid   (s_arvalid),
    .o_s_ready_c (s_arready),
    .i_s_data    (w_ar_in),
    .o_m_valid_c (m_arvalid),
    .i_m_ready   (m_arready),
    .o_m_data_c  (w_ar_out),
    .o_count     (w_ar_count)
  );

  axi_skid_throttle #(.W(R_W)) u_r (
    .clk         (clk),
    .rst         (rst),
    .i_v_ok      (w_r_v_ok),
    .i_r_ok      (w_r_r_ok),
    .i_s_valid   (m_rvalid),
    .o_s_ready_c (m_rready),
    .i_s_data    (w_r_in),
    .o_m_valid_c (s_rvalid),
    .i_m_ready   (s_rready),
    .o_m_data_c  (w_r_out),
    .o_count     (w_r_count)
  );

  assign w_stall   = ((w_ar_count != 2'd0) & ~m_arvalid) | ((w_r_count != 2'd0) & ~s_rvalid);
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live      <= 1'b0;
      r_ar_lfsr   <= SEED;
      r_r_lfsr    <= R_SEED;
      r_stall_cnt <= 32'd0;
    end else begin
      r_live    <= 1'b1;
      r_ar_lfsr <= lfsr_step(r_ar_lfsr);
      r_r_lfsr  <= lfsr_step(r_r_lfsr);
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

endmodule
